// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the MEM-stage data bus controller.
// No ports; imported by data_bus_ctrl.
package dmem_pkg;

  localparam int          DMEM_DATA_W  = 32;
  localparam int          DMEM_DEPTH   = 1024;
  localparam logic [31:0] DMEM_BASE    = 32'h0000_1500;
  localparam int          DMEM_TIMEOUT = 15;
  localparam int          DMEM_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INT  = 2'd1,
    EXT  = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, DEPTH x DATA_W, registered read.
// Ports:
//   clk    - clock
//   en     - access enable; a write or a read happens only when high
//   we     - 1 = write wdata to addr, 0 = register mem[addr] into rdata
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// MEM-stage data access controller. Accesses with cs low go to the internal
// data RAM, all others to a handshaked external bus with a timeout.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req, we, address,
//   wdata, cs           - pipeline access request (held until done), cs from decoder (0 = RAM)
//   rdata, done, err    - load result, completion pulse, timeout error pulse
//   busy                - pipeline stall, req & ~done
//   ext_req, ext_we,
//   ext_addr, ext_wdata - external bus request, registered and stable while ext_req is high
//   ext_rdata, ext_ack  - external bus response
//
// state | meaning
// IDLE  | waiting for req; internal accesses hit the RAM at the accepting edge
// INT   | internal access completing, done asserted
// EXT   | external access in flight, ext_req asserted, timeout counter running
// RESP  | external access completing, done (and err on timeout) asserted
module data_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int          DATA_W  = DMEM_DATA_W,
  parameter int          DEPTH   = DMEM_DEPTH,
  parameter logic [31:0] BASE    = DMEM_BASE,
  parameter int          TIMEOUT = DMEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cs,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              ext_req,
  output logic              ext_we,
  output logic [31:0]       ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
);

  localparam int                  AW     = $clog2(DEPTH);
  localparam logic [DMEM_CNT_W-1:0] TO_CNT = DMEM_CNT_W'(TIMEOUT);

  state_e                  state_q;
  logic [DMEM_CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    done_q;
  logic                    err_q;
  logic                    is_load_q;
  logic                    ext_req_q;
  logic                    ext_we_q;
  logic [31:0]             ext_addr_q;
  logic [DATA_W-1:0]       ext_wdata_q;

  logic                    int_accept;
  logic [AW-1:0]           ram_idx;
  logic [DATA_W-1:0]       ram_dout;

  assign int_accept = (state_q == IDLE) && req && !cs && !rst;
  // Offset is taken modulo DEPTH; the decoder guarantees cs is low only in range.
  assign ram_idx    = AW'(address - BASE);

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (int_accept),
    .we    (we),
    .addr  (ram_idx),
    .wdata (wdata),
    .rdata (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      is_load_q   <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (!cs) begin
              is_load_q <= ~we;
              done_q    <= 1'b1;
              state_q   <= INT;
            end else begin
              ext_req_q   <= 1'b1;
              ext_we_q    <= we;
              ext_addr_q  <= address;
              ext_wdata_q <= wdata;
              cnt_q       <= '0;
              state_q     <= EXT;
            end
          end
        end
        INT: begin
          // Keep the load result visible after the done cycle.
          if (is_load_q) begin
            rdata_q <= ram_dout;
          end
          state_q <= IDLE;
        end
        EXT: begin
          cnt_q <= cnt_q + 1'b1;
          // Ack takes priority over a timeout in the same cycle.
          if (ext_ack) begin
            if (!ext_we_q) begin
              rdata_q <= ext_rdata;
            end
            ext_req_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= RESP;
          end else if (cnt_q == TO_CNT) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            ext_req_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // During INT the RAM's registered output is the load result; a store leaves rdata as is.
  assign rdata     = (state_q == INT && is_load_q) ? ram_dout : rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = req & ~done_q;
  assign ext_req   = ext_req_q;
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
module tb_data_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        cs;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ack;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;

  data_bus_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .address   (address),
    .wdata     (wdata),
    .cs        (cs),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done rdata=%h err=%b cyc=%0d", rdata, err, cyc);
      end else begin
        sb_e = sb.pop_front();
        if (rdata !== sb_e.rdata || err !== sb_e.err) begin
          bad++;
          $display("FAIL sb_result got rdata=%h err=%b want rdata=%h err=%b cyc=%0d",
                   rdata, err, sb_e.rdata, sb_e.err, cyc);
        end
      end
    end
  end

  // External request fields must not move while ext_req is held.
  logic        prev_req = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr;
  logic [31:0] prev_wd;
  always @(negedge clk) begin
    if (ext_req && prev_req) begin
      total++;
      if (ext_addr !== prev_addr || ext_we !== prev_we || ext_wdata !== prev_wd) begin
        bad++;
        $display("FAIL ext_stable got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                 ext_addr, ext_we, ext_wdata, prev_addr, prev_we, prev_wd);
      end
    end
    prev_req  = ext_req;
    prev_we   = ext_we;
    prev_addr = ext_addr;
    prev_wd   = ext_wdata;
  end

  // Drives one access; ack_after = EXT cycles before ack (-1 = never).
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic c, input int ack_after, input logic [31:0] ext_d,
                        input logic [31:0] exp_rd, input logic exp_err,
                        output int lat, output logic saw_ext, output logic [31:0] ea_seen,
                        output logic ewe_seen, output logic busy_acc, output logic busy_done);
    int   n;
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    lat       = -1;
    saw_ext   = 1'b0;
    ea_seen   = 32'hFFFF_FFFF;
    ewe_seen  = 1'bx;
    busy_acc  = 1'b0;
    busy_done = 1'b1;
    @(posedge clk); #1;
    req = 1'b1; we = w; address = a; wdata = d; cs = c;
    ext_ack = 1'b0; ext_rdata = 32'hDEAD_BEEF;
    n = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) busy_acc = busy;
      if (ext_req) begin
        saw_ext  = 1'b1;
        ea_seen  = ext_addr;
        ewe_seen = ext_we;
      end
      if (done) begin
        lat       = cyc - n;
        busy_done = busy;
        break;
      end
      @(posedge clk); #1;
      ext_ack   = (ack_after >= 0) && (cyc == n + 1 + ack_after);
      ext_rdata = ext_ack ? ext_d : 32'hDEAD_BEEF;
    end
    @(posedge clk); #1;
    req = 1'b0; ext_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; address = '0; wdata = '0; cs = 1'b1;
    ext_rdata = '0; ext_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (rdata !== 32'h0)     begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (err !== 1'b0)        begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++; if (ext_req !== 1'b0)    begin bad++; $display("FAIL rst_ext_req got=%b want=0", ext_req); end
    total++; if (ext_we !== 1'b0)     begin bad++; $display("FAIL rst_ext_we got=%b want=0", ext_we); end
    total++; if (ext_addr !== 32'h0)  begin bad++; $display("FAIL rst_ext_addr got=%h want=0", ext_addr); end
    total++; if (ext_wdata !== 32'h0) begin bad++; $display("FAIL rst_ext_wdata got=%h want=0", ext_wdata); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    // Stray acks while idle must do nothing.
    @(posedge clk); #1 ext_ack = 1'b1; ext_rdata = 32'h5555_AAAA;
    repeat (2) @(posedge clk);
    #1 ext_ack = 1'b0;
    @(negedge clk);
    total++; if (rdata !== 32'h0 || ext_req !== 1'b0) begin
      bad++; $display("FAIL idle_ack got rdata=%h ext_req=%b want 0/0", rdata, ext_req);
    end
  endtask

  task automatic test_internal();
    int lat; logic se, ewe, ba, bd; logic [31:0] ea;
    access(1'b1, 32'h1500, 32'hCAFE_F00D, 1'b0, -1, 32'h0, 32'h0, 1'b0, lat, se, ea, ewe, ba, bd);
    total++; if (lat !== 1)   begin bad++; $display("FAIL int_store_lat got=%0d want=1", lat); end
    total++; if (se !== 1'b0) begin bad++; $display("FAIL int_store_ext got=%b want=0", se); end
    total++; if (ba !== 1'b1 || bd !== 1'b0) begin
      bad++; $display("FAIL int_busy got acc=%b done=%b want 1/0", ba, bd);
    end
    access(1'b0, 32'h1500, 32'h0, 1'b0, -1, 32'h0, 32'hCAFE_F00D, 1'b0, lat, se, ea, ewe, ba, bd);
    total++; if (lat !== 1)   begin bad++; $display("FAIL int_load_lat got=%0d want=1", lat); end
    total++; if (se !== 1'b0) begin bad++; $display("FAIL int_load_ext got=%b want=0", se); end
  endtask

  task automatic test_boundary();
    int lat; logic se, ewe, ba, bd; logic [31:0] ea;
    access(1'b1, 32'h18FF, 32'h1111_2222, 1'b0, -1, 32'h0, 32'hCAFE_F00D, 1'b0, lat, se, ea, ewe, ba, bd);
    access(1'b1, 32'h1500, 32'h3333_4444, 1'b0, -1, 32'h0, 32'hCAFE_F00D, 1'b0, lat, se, ea, ewe, ba, bd);
    access(1'b0, 32'h18FF, 32'h0, 1'b0, -1, 32'h0, 32'h1111_2222, 1'b0, lat, se, ea, ewe, ba, bd);
    total++; if (lat !== 1) begin bad++; $display("FAIL top_load_lat got=%0d want=1", lat); end
    access(1'b0, 32'h1500, 32'h0, 1'b0, -1, 32'h0, 32'h3333_4444, 1'b0, lat, se, ea, ewe, ba, bd);
    access(1'b0, 32'h14FF, 32'h0, 1'b1, 0, 32'h0BAD_0001, 32'h0BAD_0001, 1'b0, lat, se, ea, ewe, ba, bd);
    total++; if (se !== 1'b1 || ea !== 32'h14FF) begin
      bad++; $display("FAIL below_ext got ext=%b addr=%h want 1/000014ff", se, ea);
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL ext_min_lat got=%0d want=2", lat); end
    access(1'b0, 32'h1900, 32'h0, 1'b1, 1, 32'h0BAD_0002, 32'h0BAD_0002, 1'b0, lat, se, ea, ewe, ba, bd);
    total++; if (se !== 1'b1 || ea !== 32'h1900) begin
      bad++; $display("FAIL above_ext got ext=%b addr=%h want 1/00001900", se, ea);
    end
  endtask

  task automatic test_ext_load();
    int lat; logic se, ewe, ba, bd; logic [31:0] ea;
    access(1'b0, 32'h2000, 32'h0, 1'b1, 3, 32'h1234_5678, 32'h1234_5678, 1'b0, lat, se, ea, ewe, ba, bd);
    total++; if (ea !== 32'h2000 || ewe !== 1'b0) begin
      bad++; $display("FAIL ext_load_addr got addr=%h we=%b want 00002000/0", ea, ewe);
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL ext_load_lat got=%0d want=5", lat); end
    // An external store acknowledged keeps the previous rdata.
    access(1'b1, 32'h2004, 32'h7777_8888, 1'b1, 0, 32'h9999_9999, 32'h1234_5678, 1'b0, lat, se, ea, ewe, ba, bd);
    total++; if (ewe !== 1'b1) begin bad++; $display("FAIL ext_store_we got=%b want=1", ewe); end
  endtask

  task automatic test_ext_timeout();
    int lat; logic se, ewe, ba, bd; logic [31:0] ea;
    access(1'b1, 32'h3000, 32'hABCD_0000, 1'b1, -1, 32'h0, 32'h0, 1'b1, lat, se, ea, ewe, ba, bd);
    total++; if (lat !== 17) begin bad++; $display("FAIL timeout_lat got=%0d want=17", lat); end
    @(negedge clk);
    total++; if (ext_req !== 1'b0) begin bad++; $display("FAIL timeout_ext_req got=%b want=0", ext_req); end
    // Ack in the very cycle the counter hits the limit wins over the timeout.
    access(1'b0, 32'h3004, 32'h0, 1'b1, 15, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, lat, se, ea, ewe, ba, bd);
    total++; if (lat !== 17) begin bad++; $display("FAIL ack_on_to_lat got=%0d want=17", lat); end
    // Ack one cycle later than that is too late.
    access(1'b0, 32'h3008, 32'h0, 1'b1, 16, 32'h0F0F_0F0F, 32'h0, 1'b1, lat, se, ea, ewe, ba, bd);
    total++; if (lat !== 17) begin bad++; $display("FAIL late_ack_lat got=%0d want=17", lat); end
  endtask

  task automatic test_rst_mid();
    int   lat; logic se, ewe, ba, bd; logic [31:0] ea;
    int   dones;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; address = 32'h4000; cs = 1'b1; ext_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++; if (ext_req !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b want=1", ext_req); end
    @(negedge clk);
    total++; if (ext_req !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_mid_post got ext_req=%b done=%b want 0/0", ext_req, done);
    end
    @(posedge clk); #1 rst = 1'b0; req = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL rst_mid_done got=%0d want=0", dones); end
    access(1'b0, 32'h1500, 32'h0, 1'b0, -1, 32'h0, 32'h3333_4444, 1'b0, lat, se, ea, ewe, ba, bd);
    total++; if (lat !== 1) begin bad++; $display("FAIL rst_after_lat got=%0d want=1", lat); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [5:0] m;
    exp_t e;
    e.err = 1'b0;
    e.rdata = 32'h1111_2222; sb.push_back(e);
    e.rdata = 32'h3333_4444; sb.push_back(e);
    m = '0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; cs = 1'b0; address = 32'h18FF;
    n = cyc;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      m[k] = done;
      @(posedge clk); #1;
      if (k == 1) address = 32'h1500;
      if (k == 3) req = 1'b0;
    end
    total++; if (m !== 6'b001010) begin bad++; $display("FAIL b2b_done got=%b want=001010 n=%0d", m, n); end
  endtask

  initial begin
    test_reset();
    test_internal();
    test_boundary();
    test_ext_load();
    test_ext_timeout();
    test_rst_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
